booth_mul_core: RTL

//  Sequential radix-2 Booth multiplier engine; one Booth step per clock.

---
 rtl/mul_pkg.sv | 9 +
 rtl/booth_step.sv | 34 +++
 rtl/booth_mul_core.sv | 114 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types for the Booth multiplier engine and the pipeline register downstream of it.
// The phase word is {A[WIDTH-1:0], Q, Q_-1}; the final product is phase[2*WIDTH:1].
package mul_pkg;
    localparam int MUL_WIDTH = 32;
    localparam int PHASE_W   = 2 * MUL_WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mul_state_t;
    typedef logic [PHASE_W-1:0] phase_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step, purely combinational: add/sub/none by {Q[0],Q_-1},
// then arithmetic right shift of {A_guard,Q,Q_-1}.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
    end

    // The guard bit is replicated so A stays a valid (WIDTH+1)-bit signed value.
    assign a_next    = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];
endmodule

// File: rtl/booth_mul_core.sv
// Sequential radix-2 Booth multiplier, one step per clock; done pulses WIDTH+1 cycles after accept.
// start is ignored while busy; optional abort input when BOOTH_MUL_ABORT_EN is defined.
module booth_mul_core
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_MUL_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic [2*WIDTH:0]   phase_result,
    output logic               done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t       state;
    mul_state_t       state_nxt;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step_en;
    logic             abort_hit;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             q_m1_step;

`ifdef BOOTH_MUL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over the final step so no done is ever emitted.
                if (abort_hit) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            q_reg    <= '0;
            q_m1_reg <= 1'b0;
            m_reg    <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg    <= '0;
                q_reg    <= multiplier;
                q_m1_reg <= 1'b0;
                m_reg    <= multiplicand;
                cnt      <= CNT_W'(WIDTH);
            end else if (step_en) begin
                a_reg    <= a_step;
                q_reg    <= q_step;
                q_m1_reg <= q_m1_step;
                cnt      <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy         = (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign phase_result = {a_reg[WIDTH-1:0], q_reg, q_m1_reg};
endmodule
